// File: rtl/cgra_boot_seq.sv
// Boot/run sequencer in front of the CPU/CGRA core: loads a framed byte stream into IMEM,
// runs the core for a fixed budget, then dumps the vector result registers as bytes.
module cgra_boot_seq #(
  parameter int MAX_INSTR  = 64,
  parameter int RUN_CYCLES = 234,
  parameter int REG_BASE   = 8,
  parameter int DUMP_REGS  = 16
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        byte_ready_o,
  output logic        imem_we_o,
  output logic [5:0]  imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        cpu_rst_o,
  output logic [4:0]  reg_addr_o,
  output logic [1:0]  vout_addr_o,
  input  logic [7:0]  value_i,
  output logic        dump_valid_o,
  output logic [7:0]  dump_data_o,
  input  logic        dump_ready_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam int WC_W       = $clog2(MAX_INSTR + 1);
  localparam int RUN_W      = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam int DUMP_BYTES = DUMP_REGS * 4;
  localparam int DIDX_W     = $clog2(DUMP_BYTES);
  localparam logic [7:0] SOF = 8'hFE;
  localparam logic [7:0] EOF = 8'hFF;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DUMP, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [WC_W-1:0]     word_cnt_q, word_cnt_d;
  logic [1:0]          lane_q, lane_d;
  logic [23:0]         word_buf_q, word_buf_d;
  logic                imem_we_q, imem_we_d;
  logic [5:0]          imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                err_q, err_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
  logic [DIDX_W-1:0]   dump_idx_q, dump_idx_d;
  logic                settle_q, settle_d;
  logic                dump_valid_q, dump_valid_d;
  logic [7:0]          dump_data_q, dump_data_d;
  logic                byte_fire;

  // Byte input is only open while idle, loading or done; reset forces it shut.
  assign byte_ready_o = !reset &&
                        (state_q == S_IDLE || state_q == S_LOAD || state_q == S_DONE);
  assign byte_fire    = byte_valid_i && byte_ready_o;
  assign busy_o       = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_DUMP);
  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign cpu_rst_o    = cpu_rst_q;
  assign err_o        = err_q;
  assign dump_valid_o = dump_valid_q;
  assign dump_data_o  = dump_data_q;
  // Byte index maps to register (upper bits) and lane 3..0 (lower bits, descending).
  assign reg_addr_o   = 5'(REG_BASE) + 5'(dump_idx_q >> 2);
  assign vout_addr_o  = 2'd3 - dump_idx_q[1:0];

  always_comb begin
    // NOTE: every _d gets its hold value first so no path can infer a latch.
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    lane_d       = lane_q;
    word_buf_d   = word_buf_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    err_d        = err_q;
    cpu_rst_d    = cpu_rst_q;
    run_cnt_d    = run_cnt_q;
    dump_idx_d   = dump_idx_q;
    settle_d     = settle_q;
    dump_valid_d = dump_valid_q;
    dump_data_d  = dump_data_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (byte_fire && byte_i == SOF) begin
          state_d    = S_LOAD;
          err_d      = 1'b0;
          word_cnt_d = '0;
          lane_d     = '0;
          cpu_rst_d  = 1'b1;
          dump_idx_d = '0;
        end
      end

      S_LOAD: begin
        if (byte_fire) begin
          if (lane_q == 2'd0 && byte_i == EOF) begin
            state_d   = S_RUN;
            run_cnt_d = '0;
            cpu_rst_d = 1'b0;
          end else if (lane_q == 2'd0 && byte_i == SOF) begin
            word_cnt_d = '0;
            err_d      = 1'b0;
          end else begin
            lane_d = lane_q + 2'd1;
            unique case (lane_q)
              2'd0: word_buf_d[7:0]   = byte_i;
              2'd1: word_buf_d[15:8]  = byte_i;
              2'd2: word_buf_d[23:16] = byte_i;
              default: begin
                // Words beyond IMEM depth are flagged and dropped; lane tracking
                // continues so the closing lane-0 0xFF is still recognised.
                if (word_cnt_q == WC_W'(MAX_INSTR)) begin
                  err_d = 1'b1;
                end else begin
                  imem_we_d    = 1'b1;
                  imem_addr_d  = 6'(word_cnt_q);
                  imem_wdata_d = {byte_i, word_buf_q};
                  word_cnt_d   = word_cnt_q + WC_W'(1);
                end
              end
            endcase
          end
        end
      end

      S_RUN: begin
        if (run_cnt_q == RUN_W'(RUN_CYCLES - 1)) begin
          state_d      = S_DUMP;
          settle_d     = 1'b0;
          dump_valid_d = 1'b0;
        end else begin
          run_cnt_d = run_cnt_q + RUN_W'(1);
        end
      end

      S_DUMP: begin
        if (!dump_valid_q) begin
          // One settle cycle lets the core's registered value_o follow the new address.
          if (!settle_q) begin
            settle_d = 1'b1;
          end else begin
            settle_d     = 1'b0;
            dump_data_d  = value_i;
            dump_valid_d = 1'b1;
          end
        end else if (dump_ready_i) begin
          dump_valid_d = 1'b0;
          if (dump_idx_q == DIDX_W'(DUMP_BYTES - 1)) begin
            state_d = S_DONE;
          end else begin
            dump_idx_d = dump_idx_q + DIDX_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      word_cnt_q   <= '0;
      lane_q       <= '0;
      word_buf_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      err_q        <= 1'b0;
      cpu_rst_q    <= 1'b1;
      run_cnt_q    <= '0;
      dump_idx_q   <= '0;
      settle_q     <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_data_q  <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its _d.
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      lane_q       <= lane_d;
      word_buf_q   <= word_buf_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      err_q        <= err_d;
      cpu_rst_q    <= cpu_rst_d;
      run_cnt_q    <= run_cnt_d;
      dump_idx_q   <= dump_idx_d;
      settle_q     <= settle_d;
      dump_valid_q <= dump_valid_d;
      dump_data_q  <= dump_data_d;
    end
  end

endmodule

// File: tb/tb_cgra_boot_seq.sv
// Self-checking bench for cgra_boot_seq: random frames against a stream-level model,
// a registered core model for the dump, and directed boundary scenarios.
module tb_cgra_boot_seq;

  logic        clk_i = 1'b0;
  logic        reset = 1'b1;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_i = '0;
  logic        byte_ready_o;
  logic        imem_we_o;
  logic [5:0]  imem_addr_o;
  logic [31:0] imem_wdata_o;
  logic        cpu_rst_o;
  logic [4:0]  reg_addr_o;
  logic [1:0]  vout_addr_o;
  logic [7:0]  value_i;
  logic        dump_valid_o;
  logic [7:0]  dump_data_o;
  logic        dump_ready_i = 1'b1;
  logic        busy_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf [32];
  logic [37:0] wr_q [$];
  logic [7:0]  dump_q [$];
  logic        hold_en = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [7:0]  prev_data = '0;

  cgra_boot_seq dut (
    .clk_i(clk_i), .reset(reset),
    .byte_valid_i(byte_valid_i), .byte_i(byte_i), .byte_ready_o(byte_ready_o),
    .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
    .cpu_rst_o(cpu_rst_o), .reg_addr_o(reg_addr_o), .vout_addr_o(vout_addr_o),
    .value_i(value_i), .dump_valid_o(dump_valid_o), .dump_data_o(dump_data_o),
    .dump_ready_i(dump_ready_i), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Core model with a registered value_o, plus write/dump monitors and hold checking.
  always @(posedge clk_i) begin
    value_i <= 8'(rf[reg_addr_o] >> (8 * vout_addr_o));
    if (!reset && imem_we_o) wr_q.push_back({imem_addr_o, imem_wdata_o});
    if (!reset && dump_valid_o && dump_ready_i) dump_q.push_back(dump_data_o);
    if (hold_en && !reset && prev_valid && !prev_ready) begin
      checks++;
      if (dump_valid_o !== 1'b1 || dump_data_o !== prev_data) begin
        errors++;
        $display("FAIL dump_hold: valid=%b data=%02h, required valid=1 data=%02h",
                 dump_valid_o, dump_data_o, prev_data);
      end
    end
    prev_valid = dump_valid_o;
    prev_ready = dump_ready_i;
    prev_data  = dump_data_o;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    byte_valid_i = 1'b1;
    byte_i       = b;
    while (!byte_ready_o && t < 50) begin
      @(negedge clk_i);
      t++;
    end
    if (!byte_ready_o) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte_ready_o stayed 0 for byte %02h", b);
    end
    @(negedge clk_i);
    byte_valid_i = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] s [$]);
    foreach (s[i]) send_byte(s[i]);
  endtask

  // Stream-level reference: framing, little-endian packing, IMEM-depth limit.
  task automatic model(input logic [7:0] s [$], output logic [37:0] exp [$],
                       output logic exp_err);
    bit          in_frame = 0;
    int          lane = 0;
    int          cnt = 0;
    logic [31:0] w = '0;
    exp.delete();
    exp_err = 1'b0;
    foreach (s[i]) begin
      if (!in_frame) begin
        if (s[i] == 8'hFE) begin
          in_frame = 1;
          cnt = 0;
          lane = 0;
          exp_err = 1'b0;
        end
      end else if (lane == 0 && s[i] == 8'hFF) begin
        in_frame = 0;
      end else if (lane == 0 && s[i] == 8'hFE) begin
        cnt = 0;
        exp_err = 1'b0;
      end else begin
        w[8*lane +: 8] = s[i];
        lane++;
        if (lane == 4) begin
          lane = 0;
          if (cnt < 64) begin
            exp.push_back({6'(cnt), w});
            cnt++;
          end else begin
            exp_err = 1'b1;
          end
        end
      end
    end
  endtask

  function automatic logic [7:0] golden(input int k);
    return 8'(rf[8 + k / 4] >> (8 * (3 - k % 4)));
  endfunction

  function automatic int dump_mismatch();
    if (dump_q.size() != 64) return 64;
    for (int k = 0; k < 64; k++) if (dump_q[k] !== golden(k)) return k;
    return -1;
  endfunction

  function automatic int wr_mismatch(input logic [37:0] exp [$]);
    if (wr_q.size() != exp.size()) return 1000;
    foreach (exp[i]) if (wr_q[i] !== exp[i]) return i;
    return -1;
  endfunction

  task automatic push_word(inout logic [7:0] s [$], input logic [31:0] w);
    s.push_back(8'($urandom_range(0, 253)));
    s.push_back(w[15:8]);
    s.push_back(w[23:16]);
    s.push_back(w[31:24]);
  endtask

  task automatic wait_done();
    int t = 0;
    while (busy_o && t < 5000) begin
      @(negedge clk_i);
      t++;
    end
    checks++;
    if (busy_o !== 1'b0 || cpu_rst_o !== 1'b0 || byte_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL done_state: busy=%b cpu_rst=%b ready=%b after %0d cycles, required 0 0 1",
               busy_o, cpu_rst_o, byte_ready_o, t);
    end
  endtask

  task automatic check_frame(input string name, input logic [7:0] s [$]);
    logic [37:0] exp [$];
    logic        exp_err;
    int          m;
    model(s, exp, exp_err);
    m = wr_mismatch(exp);
    checks++;
    if (m != -1) begin
      errors++;
      $display("FAIL %s_writes: got %0d writes (first bad %0d), required %0d writes",
               name, wr_q.size(), m, exp.size());
    end
    checks++;
    if (err_o !== exp_err) begin
      errors++;
      $display("FAIL %s_err: err_o=%b, required %b", name, err_o, exp_err);
    end
  endtask

  task automatic check_dump(input string name);
    int m;
    m = dump_mismatch();
    checks++;
    if (m != -1) begin
      errors++;
      if (m == 64) $display("FAIL %s_dump: got %0d bytes, required 64", name, dump_q.size());
      else $display("FAIL %s_dump: byte %0d = %02h, required %02h", name, m, dump_q[m], golden(m));
    end
  endtask

  task automatic new_frame_setup();
    foreach (rf[i]) rf[i] = $urandom;
    wr_q.delete();
    dump_q.delete();
  endtask

  task automatic test_reset();
    checks++;
    if (cpu_rst_o !== 1'b1 || reg_addr_o !== 5'd8 || vout_addr_o !== 2'd3) begin
      errors++;
      $display("FAIL reset_core: cpu_rst=%b reg=%0d lane=%0d, required 1 8 3",
               cpu_rst_o, reg_addr_o, vout_addr_o);
    end
    checks++;
    if ({byte_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, dump_valid_o, dump_data_o,
         busy_o, err_o} !== '0) begin
      errors++;
      $display("FAIL reset_zero: ready=%b we=%b addr=%0d wdata=%08h dv=%b dd=%02h busy=%b err=%b, required all 0",
               byte_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, dump_valid_o,
               dump_data_o, busy_o, err_o);
    end
    reset = 1'b0;
    tick(2);
    checks++;
    if (byte_ready_o !== 1'b1 || busy_o !== 1'b0 || cpu_rst_o !== 1'b1) begin
      errors++;
      $display("FAIL idle_state: ready=%b busy=%b cpu_rst=%b, required 1 0 1",
               byte_ready_o, busy_o, cpu_rst_o);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] s [$] = '{8'h00, 8'hFE, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hFF};
    int n = 0;
    new_frame_setup();
    send_stream(s);
    checks++;
    if (cpu_rst_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL single_release: cpu_rst=%b busy=%b, required 0 1", cpu_rst_o, busy_o);
    end
    checks++;
    if (wr_q.size() != 1 || wr_q[0] !== {6'd0, 32'h00A00513}) begin
      errors++;
      $display("FAIL single_write: got %0d writes, first %h, required 1 write 000a00513",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 38'h0);
    end
    while (!dump_valid_o && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    // 234 run cycles, then one settle cycle and one capture cycle.
    checks++;
    if (n != 236) begin
      errors++;
      $display("FAIL run_budget: dump_valid rose %0d cycles after release, required 236", n);
    end
    wait_done();
    check_frame("single", s);
    check_dump("single");
  endtask

  task automatic test_lane_ff();
    logic [7:0] s [$] = '{8'hFE, 8'h13, 8'h05, 8'hFF, 8'hFF};
    new_frame_setup();
    send_stream(s);
    tick(6);
    checks++;
    if (busy_o !== 1'b1 || cpu_rst_o !== 1'b1 || wr_q.size() != 1) begin
      errors++;
      $display("FAIL lane_ff_load: busy=%b cpu_rst=%b writes=%0d, required 1 1 1",
               busy_o, cpu_rst_o, wr_q.size());
    end
    send_byte(8'hFF);
    s.push_back(8'hFF);
    checks++;
    if (cpu_rst_o !== 1'b0 || wr_q.size() != 1 || wr_q[0][31:0] !== 32'hFFFF0513) begin
      errors++;
      $display("FAIL lane_ff_end: cpu_rst=%b writes=%0d, required 0 and one write ffff0513",
               cpu_rst_o, wr_q.size());
    end
    check_frame("lane_ff", s);
    wait_done();
  endtask

  task automatic test_overflow();
    logic [7:0] s [$];
    new_frame_setup();
    s.push_back(8'hFE);
    for (int i = 0; i < 65; i++) push_word(s, $urandom);
    s.push_back(8'hFF);
    send_stream(s);
    tick(2);
    checks++;
    if (wr_q.size() != 64 || err_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_count: writes=%0d err=%b, required 64 1", wr_q.size(), err_o);
    end
    check_frame("overflow", s);
    wait_done();
    check_dump("overflow");
  endtask

  task automatic test_done_reload();
    logic [7:0] s [$];
    new_frame_setup();
    send_byte(8'h42);
    send_byte(8'hFE);
    checks++;
    if (err_o !== 1'b0 || cpu_rst_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL done_reload: err=%b cpu_rst=%b busy=%b, required 0 1 1",
               err_o, cpu_rst_o, busy_o);
    end
    s = '{8'h42, 8'hFE};
    for (int i = 0; i < 2; i++) push_word(s, $urandom);
    s.push_back(8'hFF);
    send_stream(s[2:$]);
    tick(2);
    check_frame("reload", s);
    wait_done();
    check_dump("reload");
  endtask

  task automatic test_random_frames();
    for (int it = 0; it < 3; it++) begin
      logic [7:0] s [$];
      new_frame_setup();
      repeat ($urandom_range(0, 3)) s.push_back(8'($urandom_range(0, 253)));
      s.push_back(8'hFE);
      repeat ($urandom_range(1, 6)) push_word(s, $urandom);
      if ($urandom_range(0, 1) == 1) s.push_back(8'hFE);
      repeat ($urandom_range(1, 6)) push_word(s, $urandom);
      s.push_back(8'hFF);
      send_stream(s);
      tick(2);
      check_frame("random", s);
      wait_done();
      check_dump("random");
    end
  endtask

  task automatic test_dump_backpressure();
    logic [7:0] s [$];
    int c = 0;
    new_frame_setup();
    s.push_back(8'hFE);
    push_word(s, $urandom);
    s.push_back(8'hFF);
    send_stream(s);
    hold_en = 1'b1;
    while (busy_o && c < 5000) begin
      if (c % 3 == 0) dump_ready_i = ~dump_ready_i;
      @(negedge clk_i);
      c++;
    end
    hold_en = 1'b0;
    dump_ready_i = 1'b1;
    wait_done();
    check_dump("backpressure");
  endtask

  task automatic test_reset_mid_dump();
    logic [7:0] s [$];
    int t = 0;
    new_frame_setup();
    s.push_back(8'hFE);
    push_word(s, $urandom);
    s.push_back(8'hFF);
    send_stream(s);
    while (dump_q.size() < 20 && t < 2000) begin
      @(negedge clk_i);
      t++;
    end
    reset = 1'b1;
    tick(1);
    checks++;
    if (cpu_rst_o !== 1'b1 || dump_valid_o !== 1'b0 || busy_o !== 1'b0 ||
        reg_addr_o !== 5'd8 || vout_addr_o !== 2'd3 || dump_q.size() != 20) begin
      errors++;
      $display("FAIL reset_mid_dump: cpu_rst=%b dv=%b busy=%b reg=%0d lane=%0d bytes=%0d, required 1 0 0 8 3 20",
               cpu_rst_o, dump_valid_o, busy_o, reg_addr_o, vout_addr_o, dump_q.size());
    end
    reset = 1'b0;
    tick(2);
    new_frame_setup();
    s.delete();
    s.push_back(8'hFE);
    for (int i = 0; i < 3; i++) push_word(s, $urandom);
    s.push_back(8'hFF);
    send_stream(s);
    tick(2);
    check_frame("after_reset", s);
    wait_done();
    check_dump("after_reset");
  endtask

  initial begin
    foreach (rf[i]) rf[i] = '0;
    tick(3);
    test_reset();
    test_single_word();
    test_lane_ff();
    test_overflow();
    test_done_reload();
    test_random_frames();
    test_dump_backpressure();
    test_reset_mid_dump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
